netwalk_tcam_pipe_core: RTL and testbench
=========================================

Name: netwalk_tcam_pipe_core

Overview:
Parametrised, pipelined successor to the single-cycle TCAM core in the NETWALK data plane.
- Stores TCAM_SIZE ternary entries with per-entry valid bits.
- Accepts tagged lookups through a valid/ready handshake and returns a priority-encoded result (lowest index wins) after a fixed 2-cycle latency.
- Adds a multi-match flag, a valid-entry counter and an out-of-range programming error.
- Sits between the packet-header field extractor and the flow-action lookup.

Parameters:
TCAM_SIZE, 64, number of entries.
TCAM_ADDR_WIDTH, 8, entry address width; 2^TCAM_ADDR_WIDTH >= TCAM_SIZE.
DPL_MATCH_FIELD_WIDTH, 356, key/data/mask width in bits.
TAG_WIDTH, 8, width of the opaque lookup tag carried to the result.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- tcam_program_data  in  DPL_MATCH_FIELD_WIDTH  entry data.
- tcam_program_mask  in  DPL_MATCH_FIELD_WIDTH  care mask; 1 = compare this bit, 0 = don't care.
- tcam_program_addr  in  TCAM_ADDR_WIDTH  target entry.
- tcam_program_enable  in  1  write/delete strobe, one operation per cycle.
- tcam_delete_enable  in  1  qualifies tcam_program_enable as a delete.
- tcam_program_ack  out  1  1-cycle pulse, the cycle after each program/delete.
- tcam_program_error  out  1  pulses with ack when the address was >= TCAM_SIZE.
- lookup_valid  in  1  lookup request.
- lookup_ready  out  1  combinational; equals NOT tcam_program_enable while out of reset.
- lookup_key  in  DPL_MATCH_FIELD_WIDTH  search key.
- lookup_tag  in  TAG_WIDTH  opaque tag.
- result_valid  out  1  1-cycle result strobe.
- result_hit  out  1  at least one entry matched.
- result_miss  out  1  no entry matched (table miss).
- result_multi  out  1  two or more entries matched.
- result_onehot  out  TCAM_SIZE  raw match vector.
- result_addr  out  TCAM_ADDR_WIDTH  lowest matching index; 0 on miss.
- result_tag  out  TAG_WIDTH  tag of the request.
- entry_count  out  TCAM_ADDR_WIDTH+1  number of valid entries.

Behaviour:
Reset (reset == 0 at a clock edge):
- All valid bits and both pipeline valid flags are cleared.
- Every output is 0: ack, error, result_*, entry_count.
- lookup_ready is held 0 while reset is low.
- Data and mask storage is not reset.
- Lookups in flight when reset asserts are dropped and produce no result_valid.

Matching:
- Entry i matches when valid[i] is set and ((key XOR data[i]) AND mask[i]) == 0.
- An entry programmed with an all-zero mask matches every key.

Program and delete (tcam_program_enable=1, at the edge):
- If addr < TCAM_SIZE and delete=0: data and mask are written and valid is set. entry_count increments only if the entry was previously invalid; an overwrite leaves it unchanged.
- If addr < TCAM_SIZE and delete=1: valid is cleared. entry_count decrements only if the entry was valid.
- If addr >= TCAM_SIZE: no state change, and tcam_program_error pulses alongside tcam_program_ack.
- Back-to-back operations are allowed, one per cycle, with one ack per operation.

Lookup pipeline (edges E0, E1, E2):
- E0, accept: a lookup is accepted when lookup_valid & lookup_ready. Key and tag are registered in stage S1.
- E1, compare: the match vector is computed from entry state as it stands before E1 and registered in S2. A write committing at E1 is therefore not seen by this lookup.
- E2, encode: the priority encoder output is registered, and result_* is presented with result_valid=1 in the cycle after E2.
- Throughput is one lookup per cycle with no output backpressure.
- result_valid is a 1-cycle pulse. Outside a valid cycle, result_* holds its last value.
- hit/miss: result_hit = OR of the vector; result_miss = NOT result_hit when valid.
- multi: result_multi=1 when popcount >= 2.
- A lookup arriving while tcam_program_enable=1 is not accepted. The requester holds it; a lookup and a program operation are never accepted in the same cycle.
- Deleted entries never match.

Boundaries:
- entry_count saturates logically at TCAM_SIZE; it cannot exceed this by construction.
- The highest index TCAM_SIZE-1 is addressable.
- A lookup on an empty table returns miss with result_addr=0.

Test Plan:
1. Release reset, program entries 0–4 with distinct data and full masks. Expect 5 acks, entry_count=5, no error.
2. Look up key == data[2] with tag 8'h5A. Expect result_valid exactly 2 edges after acceptance, hit=1, addr=2, onehot=64'h4, tag=8'h5A, multi=0.
3. Program entry 1 with mask 0 (wildcard) and look up data[3]. Expect addr=1, multi=1, onehot=64'hA.
4. Delete entry 1 (program_enable=1, delete_enable=1), then repeat the lookup. Expect addr=3, multi=0, entry_count=4; deleting entry 1 again leaves entry_count=4.
5. Assert lookup_valid during a program cycle. Expect lookup_ready=0 and acceptance on the next cycle. Issue 4 back-to-back lookups and expect 4 consecutive result_valid pulses in order, with matching tags.
6. Program addr=70 and expect ack plus error with entry_count unchanged. Assert reset with 2 lookups in flight: expect no result_valid, entry_count=0, and a lookup of data[2] returning miss=1.

Source files
------------

// File: rtl/netwalk_tcam_pipe_core.sv
// Pipelined ternary match table: one-op-per-cycle program/delete port and a
// fixed 2-cycle priority-encoded lookup pipe (lowest matching index wins).
module netwalk_tcam_pipe_core #(
  parameter int unsigned TCAM_SIZE             = 64,
  parameter int unsigned TCAM_ADDR_WIDTH       = 8,
  parameter int unsigned DPL_MATCH_FIELD_WIDTH = 356,
  parameter int unsigned TAG_WIDTH             = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DPL_MATCH_FIELD_WIDTH-1:0] tcam_program_data,
  input  logic [DPL_MATCH_FIELD_WIDTH-1:0] tcam_program_mask,
  input  logic [TCAM_ADDR_WIDTH-1:0]       tcam_program_addr,
  input  logic                             tcam_program_enable,
  input  logic                             tcam_delete_enable,
  output logic                             tcam_program_ack,
  output logic                             tcam_program_error,
  input  logic                             lookup_valid,
  output logic                             lookup_ready,
  input  logic [DPL_MATCH_FIELD_WIDTH-1:0] lookup_key,
  input  logic [TAG_WIDTH-1:0]             lookup_tag,
  output logic                             result_valid,
  output logic                             result_hit,
  output logic                             result_miss,
  output logic                             result_multi,
  output logic [TCAM_SIZE-1:0]             result_onehot,
  output logic [TCAM_ADDR_WIDTH-1:0]       result_addr,
  output logic [TAG_WIDTH-1:0]             result_tag,
  output logic [TCAM_ADDR_WIDTH:0]         entry_count
);

  localparam int unsigned IDX_W = (TCAM_SIZE > 1) ? $clog2(TCAM_SIZE) : 1;
  localparam int unsigned CNT_W = TCAM_ADDR_WIDTH + 1;

  // Entry storage: data/mask are never reset, only the valid bits are.
  logic [DPL_MATCH_FIELD_WIDTH-1:0] data_q [TCAM_SIZE];
  logic [DPL_MATCH_FIELD_WIDTH-1:0] mask_q [TCAM_SIZE];
  logic [TCAM_SIZE-1:0]             valid_q;

  logic             in_range_c;
  logic             prog_write_c;
  logic             prog_delete_c;
  logic [IDX_W-1:0] prog_idx_c;
  logic             lookup_accept_c;

  // Stage registers
  logic                             s1_valid;
  logic [DPL_MATCH_FIELD_WIDTH-1:0] s1_key;
  logic [TAG_WIDTH-1:0]             s1_tag;
  logic                             s2_valid;
  logic [TCAM_SIZE-1:0]             s2_vec;
  logic [TAG_WIDTH-1:0]             s2_tag;

  logic [TCAM_SIZE-1:0]       match_c;
  logic [TCAM_ADDR_WIDTH-1:0] enc_addr_c;
  logic                       enc_hit_c;
  logic                       enc_multi_c;

  // Program decode; nothing commits while reset is low
  assign in_range_c      = CNT_W'(tcam_program_addr) < CNT_W'(TCAM_SIZE);
  assign prog_idx_c      = IDX_W'(tcam_program_addr);
  assign prog_write_c    = reset & tcam_program_enable & ~tcam_delete_enable & in_range_c;
  assign prog_delete_c   = reset & tcam_program_enable &  tcam_delete_enable & in_range_c;

  // Lookups yield to program operations so the two never share a cycle
  assign lookup_ready    = reset & ~tcam_program_enable;
  assign lookup_accept_c = lookup_valid & lookup_ready;

  // Data/mask write port
  always_ff @(posedge clk) begin
    if (prog_write_c) begin
      data_q[prog_idx_c] <= tcam_program_data;
      mask_q[prog_idx_c] <= tcam_program_mask;
    end
  end

  // Valid bits and occupancy count; count moves only on a real state change
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q     <= '0;
      entry_count <= '0;
    end else if (prog_write_c && !valid_q[prog_idx_c]) begin
      valid_q[prog_idx_c] <= 1'b1;
      entry_count         <= entry_count + CNT_W'(1);
    end else if (prog_delete_c && valid_q[prog_idx_c]) begin
      valid_q[prog_idx_c] <= 1'b0;
      entry_count         <= entry_count - CNT_W'(1);
    end
  end

  // Program acknowledge and out-of-range flag, one cycle after the strobe
  always_ff @(posedge clk) begin
    if (!reset) begin
      tcam_program_ack   <= 1'b0;
      tcam_program_error <= 1'b0;
    end else begin
      tcam_program_ack   <= tcam_program_enable;
      tcam_program_error <= tcam_program_enable & ~in_range_c;
    end
  end

  // S1: capture accepted key and tag
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= lookup_accept_c;
      if (lookup_accept_c) begin
        s1_key <= lookup_key;
        s1_tag <= lookup_tag;
      end
    end
  end

  // Ternary compare of the S1 key against every entry
  always_comb begin
    match_c = '0;
    for (int i = 0; i < int'(TCAM_SIZE); i++) begin
      match_c[i] = valid_q[i] & ~(|((s1_key ^ data_q[i]) & mask_q[i]));
    end
  end

  // S2: register the raw match vector
  always_ff @(posedge clk) begin
    if (!reset) begin
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_vec <= match_c;
        s2_tag <= s1_tag;
      end
    end
  end

  // Priority encode: scanning downward leaves the lowest set index
  always_comb begin
    enc_addr_c = '0;
    for (int i = int'(TCAM_SIZE) - 1; i >= 0; i--) begin
      if (s2_vec[i]) begin
        enc_addr_c = TCAM_ADDR_WIDTH'(i);
      end
    end
  end

  assign enc_hit_c   = |s2_vec;
  // Clearing the lowest set bit leaves something only if two or more were set
  assign enc_multi_c = |(s2_vec & (s2_vec - TCAM_SIZE'(1)));

  // Result registers: strobe for one cycle, fields hold between results
  always_ff @(posedge clk) begin
    if (!reset) begin
      result_valid  <= 1'b0;
      result_hit    <= 1'b0;
      result_miss   <= 1'b0;
      result_multi  <= 1'b0;
      result_onehot <= '0;
      result_addr   <= '0;
      result_tag    <= '0;
    end else begin
      result_valid <= s2_valid;
      if (s2_valid) begin
        result_hit    <= enc_hit_c;
        result_miss   <= ~enc_hit_c;
        result_multi  <= enc_multi_c;
        result_onehot <= s2_vec;
        result_addr   <= enc_addr_c;
        result_tag    <= s2_tag;
      end
    end
  end

endmodule

// File: tb/tb_netwalk_tcam_pipe_core.sv
// Randomized bench for netwalk_tcam_pipe_core against a table-level reference model.
module tb_netwalk_tcam_pipe_core;

  localparam int unsigned N  = 64;
  localparam int unsigned AW = 8;
  localparam int unsigned W  = 356;
  localparam int unsigned TW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  tcam_program_data;
  logic [W-1:0]  tcam_program_mask;
  logic [AW-1:0] tcam_program_addr;
  logic          tcam_program_enable;
  logic          tcam_delete_enable;
  logic          tcam_program_ack;
  logic          tcam_program_error;
  logic          lookup_valid;
  logic          lookup_ready;
  logic [W-1:0]  lookup_key;
  logic [TW-1:0] lookup_tag;
  logic          result_valid;
  logic          result_hit;
  logic          result_miss;
  logic          result_multi;
  logic [N-1:0]  result_onehot;
  logic [AW-1:0] result_addr;
  logic [TW-1:0] result_tag;
  logic [AW:0]   entry_count;

  always #5 clk = ~clk;

  netwalk_tcam_pipe_core #(
    .TCAM_SIZE(N), .TCAM_ADDR_WIDTH(AW), .DPL_MATCH_FIELD_WIDTH(W), .TAG_WIDTH(TW)
  ) dut (
    .clk(clk), .reset(reset),
    .tcam_program_data(tcam_program_data), .tcam_program_mask(tcam_program_mask),
    .tcam_program_addr(tcam_program_addr), .tcam_program_enable(tcam_program_enable),
    .tcam_delete_enable(tcam_delete_enable), .tcam_program_ack(tcam_program_ack),
    .tcam_program_error(tcam_program_error), .lookup_valid(lookup_valid),
    .lookup_ready(lookup_ready), .lookup_key(lookup_key), .lookup_tag(lookup_tag),
    .result_valid(result_valid), .result_hit(result_hit), .result_miss(result_miss),
    .result_multi(result_multi), .result_onehot(result_onehot), .result_addr(result_addr),
    .result_tag(result_tag), .entry_count(entry_count)
  );

  typedef struct {
    logic [N-1:0]  onehot;
    logic [AW-1:0] addr;
    logic          hit;
    logic          miss;
    logic          multi;
    logic [TW-1:0] tag;
  } res_t;

  typedef struct {
    logic [W-1:0]  key;
    logic [TW-1:0] tag;
    int            cyc;
  } req_t;

  typedef struct {
    res_t r;
    int   due;
  } exp_t;

  // Reference table
  logic [W-1:0] md [N];
  logic [W-1:0] mm [N];
  logic [N-1:0] mv;
  int           mcount;

  req_t          pend[$];
  exp_t          expq[$];
  res_t          last;
  logic [TW-1:0] seen_tags[$];
  logic [W-1:0]  dd [5];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic res_t zero_res();
    res_t r;
    r.onehot = '0; r.addr = '0; r.hit = 1'b0; r.miss = 1'b0; r.multi = 1'b0; r.tag = '0;
    return r;
  endfunction

  // Lookup against the table as it stands now
  function automatic res_t model_lookup(input logic [W-1:0] key, input logic [TW-1:0] tag);
    res_t r;
    int   hits;
    r = zero_res();
    hits = 0;
    for (int i = 0; i < int'(N); i++) begin
      if (mv[i] && (((key ^ md[i]) & mm[i]) == '0)) begin
        if (hits == 0) r.addr = AW'(i);
        hits++;
        r.onehot[i] = 1'b1;
      end
    end
    r.hit   = (hits > 0);
    r.miss  = (hits == 0);
    r.multi = (hits >= 2);
    r.tag   = tag;
    return r;
  endfunction

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < int'((W + 31) / 32); i++) v = {v[W-33:0], 32'($urandom)};
    return v;
  endfunction

  function automatic logic [W-1:0] rand_mask();
    case ($urandom_range(0, 7))
      0, 1, 2: return '1;
      3:       return '0;
      4, 5:    return W'(4'hF);
      default: return rand_wide() & rand_wide() & rand_wide();
    endcase
  endfunction

  function automatic logic [W-1:0] rand_key();
    int k;
    if ($urandom_range(0, 3) == 0) return rand_wide();
    k = int'($urandom_range(0, N - 1));
    return md[k] ^ (rand_wide() & ~mm[k]);
  endfunction

  // One clock: check ready, advance the model at the edge, then check outputs
  task automatic tick();
    logic exp_ack, exp_err;
    int   a;
    exp_t e;
    req_t q;
    #1;
    check("lookup_ready", 64'(lookup_ready), 64'(reset && !tcam_program_enable));
    @(posedge clk);
    cyc++;
    exp_ack = 1'b0;
    exp_err = 1'b0;
    if (!reset) begin
      mv = '0;
      mcount = 0;
      pend.delete();
      expq.delete();
      last = zero_res();
    end else begin
      // Lookups accepted last edge see the table before this edge's write
      while (pend.size() > 0 && pend[0].cyc == cyc - 1) begin
        e.r   = model_lookup(pend[0].key, pend[0].tag);
        e.due = cyc + 1;
        expq.push_back(e);
        void'(pend.pop_front());
      end
      if (tcam_program_enable) begin
        exp_ack = 1'b1;
        a = int'(tcam_program_addr);
        if (a >= int'(N)) begin
          exp_err = 1'b1;
        end else if (tcam_delete_enable) begin
          if (mv[a]) mcount--;
          mv[a] = 1'b0;
        end else begin
          if (!mv[a]) mcount++;
          mv[a] = 1'b1;
          md[a] = tcam_program_data;
          mm[a] = tcam_program_mask;
        end
      end else if (lookup_valid) begin
        q.key = lookup_key;
        q.tag = lookup_tag;
        q.cyc = cyc;
        pend.push_back(q);
      end
    end
    #1;
    check("program_ack", 64'(tcam_program_ack), 64'(exp_ack));
    check("program_error", 64'(tcam_program_error), 64'(exp_err));
    check("entry_count", 64'(entry_count), 64'(mcount));
    if (expq.size() > 0 && expq[0].due == cyc) begin
      last = expq[0].r;
      void'(expq.pop_front());
      check("result_valid", 64'(result_valid), 64'd1);
    end else begin
      check("result_valid", 64'(result_valid), 64'd0);
    end
    if (result_valid) seen_tags.push_back(result_tag);
    check("result_hit", 64'(result_hit), 64'(last.hit));
    check("result_miss", 64'(result_miss), 64'(last.miss));
    check("result_multi", 64'(result_multi), 64'(last.multi));
    check("result_onehot", 64'(result_onehot), 64'(last.onehot));
    check("result_addr", 64'(result_addr), 64'(last.addr));
    check("result_tag", 64'(result_tag), 64'(last.tag));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_prog(input int addr, input logic [W-1:0] d, input logic [W-1:0] m,
                         input logic del);
    tcam_program_addr   = AW'(addr);
    tcam_program_data   = d;
    tcam_program_mask   = m;
    tcam_delete_enable  = del;
    tcam_program_enable = 1'b1;
    tick();
    tcam_program_enable = 1'b0;
    tcam_delete_enable  = 1'b0;
  endtask

  task automatic do_lookup(input logic [W-1:0] key, input logic [TW-1:0] tag);
    lookup_key   = key;
    lookup_tag   = tag;
    lookup_valid = 1'b1;
    tick();
    lookup_valid = 1'b0;
  endtask

  initial begin
    logic hold;
    for (int i = 0; i < int'(N); i++) begin
      md[i] = '0;
      mm[i] = '0;
    end
    mv = '0;
    mcount = 0;
    last = zero_res();
    reset = 1'b0;
    tcam_program_data = '0;
    tcam_program_mask = '0;
    tcam_program_addr = '0;
    tcam_program_enable = 1'b0;
    tcam_delete_enable = 1'b0;
    lookup_valid = 1'b0;
    lookup_key = '0;
    lookup_tag = '0;
    idle(3);
    reset = 1'b1;
    idle(1);

    // 1: five distinct exact-match entries
    for (int i = 0; i < 5; i++) begin
      dd[i] = rand_wide();
      do_prog(i, dd[i], '1, 1'b0);
    end
    check("t1_count", 64'(entry_count), 64'd5);

    // 2: exact hit on entry 2
    do_lookup(dd[2], 8'h5A);
    idle(2);
    check("t2_valid", 64'(result_valid), 64'd1);
    check("t2_addr", 64'(result_addr), 64'd2);
    check("t2_onehot", 64'(result_onehot), 64'h4);
    check("t2_tag", 64'(result_tag), 64'h5A);
    check("t2_multi", 64'(result_multi), 64'd0);

    // 3: wildcard at entry 1 shadows entry 3
    do_prog(1, dd[1], '0, 1'b0);
    do_lookup(dd[3], 8'h33);
    idle(2);
    check("t3_addr", 64'(result_addr), 64'd1);
    check("t3_multi", 64'(result_multi), 64'd1);
    check("t3_onehot", 64'(result_onehot), 64'hA);

    // 4: delete entry 1, twice
    do_prog(1, '0, '0, 1'b1);
    do_lookup(dd[3], 8'h44);
    idle(2);
    check("t4_addr", 64'(result_addr), 64'd3);
    check("t4_multi", 64'(result_multi), 64'd0);
    check("t4_count", 64'(entry_count), 64'd4);
    do_prog(1, '0, '0, 1'b1);
    check("t4_count_redelete", 64'(entry_count), 64'd4);

    // 5: lookup held across a program cycle, then 4 back-to-back
    seen_tags.delete();
    lookup_key = dd[0];
    lookup_tag = 8'h77;
    lookup_valid = 1'b1;
    tcam_program_addr = AW'(4);
    tcam_program_data = dd[4];
    tcam_program_mask = '1;
    tcam_program_enable = 1'b1;
    #1;
    check("t5_ready_blocked", 64'(lookup_ready), 64'd0);
    tick();
    tcam_program_enable = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      lookup_key = dd[i];
      lookup_tag = TW'(8'hA0 + i);
      tick();
    end
    lookup_valid = 1'b0;
    idle(3);
    check("t5_result_count", 64'(seen_tags.size()), 64'd5);
    if (seen_tags.size() == 5) begin
      check("t5_tag0", 64'(seen_tags[0]), 64'h77);
      for (int i = 0; i < 4; i++) check("t5_tag", 64'(seen_tags[i+1]), 64'(8'hA0 + i));
    end

    // 6: out-of-range program, then reset with lookups in flight
    do_prog(70, rand_wide(), '1, 1'b0);
    check("t6_error", 64'(tcam_program_error), 64'd1);
    check("t6_count", 64'(entry_count), 64'd4);
    do_lookup(dd[2], 8'h01);
    do_lookup(dd[3], 8'h02);
    reset = 1'b0;
    idle(2);
    check("t6_count_reset", 64'(entry_count), 64'd0);
    reset = 1'b1;
    idle(3);
    check("t6_no_result", 64'(result_valid), 64'd0);
    do_lookup(dd[2], 8'h03);
    idle(2);
    check("t6_miss", 64'(result_miss), 64'd1);
    check("t6_miss_addr", 64'(result_addr), 64'd0);

    // Random traffic: requester holds a blocked lookup until accepted
    hold = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      reset = ($urandom_range(0, 399) != 0);
      if (!hold) begin
        lookup_valid = ($urandom_range(0, 9) < 6);
        lookup_key   = rand_key();
        lookup_tag   = TW'($urandom);
      end
      tcam_program_enable = ($urandom_range(0, 9) < 3);
      tcam_delete_enable  = ($urandom_range(0, 3) == 0);
      tcam_program_addr   = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(N, 255))
                                                        : AW'($urandom_range(0, N - 1));
      tcam_program_data   = rand_wide();
      tcam_program_mask   = rand_mask();
      hold = lookup_valid && (tcam_program_enable || !reset);
      tick();
    end
    reset = 1'b1;
    lookup_valid = 1'b0;
    tcam_program_enable = 1'b0;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
